// File: rtl/sha2_conduit_arbiter_if.sv
// rtl/sha2_conduit_arbiter_if.sv - requester-side and core-side conduit bundles for sha2_conduit_arbiter
interface sha2_conduit_req_if #(
  parameter int D_WIDTH = 32,
  parameter int N_REQ   = 2
);
  logic [N_REQ-1:0]             req_wr;
  logic [N_REQ-1:0]             req_rd;
  logic [N_REQ*12-1:0]          req_addr;
  logic [N_REQ*D_WIDTH-1:0]     req_wdata;
  logic [N_REQ*D_WIDTH/8-1:0]   req_wbe;
  logic [N_REQ-1:0]             req_wr_ack;
  logic [N_REQ-1:0]             req_read_valid;
  logic [N_REQ-1:0]             req_slv_error;
  logic [N_REQ*D_WIDTH-1:0]     req_rdata;
  logic [N_REQ-1:0]             req_ovf;

  modport master (
    output req_wr, req_rd, req_addr, req_wdata, req_wbe,
    input  req_wr_ack, req_read_valid, req_slv_error, req_rdata, req_ovf
  );
  modport slave (
    input  req_wr, req_rd, req_addr, req_wdata, req_wbe,
    output req_wr_ack, req_read_valid, req_slv_error, req_rdata, req_ovf
  );
endinterface

interface sha2_conduit_core_if #(
  parameter int D_WIDTH = 32
);
  logic                   core_wr;
  logic                   core_rd;
  logic [11:0]            core_addr;
  logic [D_WIDTH-1:0]     core_wdata;
  logic [D_WIDTH/8-1:0]   core_wbe;
  logic                   core_wr_ack;
  logic                   core_read_valid;
  logic                   core_slv_error;
  logic [D_WIDTH-1:0]     core_rdata;

  modport master (
    output core_wr, core_rd, core_addr, core_wdata, core_wbe,
    input  core_wr_ack, core_read_valid, core_slv_error, core_rdata
  );
  modport slave (
    input  core_wr, core_rd, core_addr, core_wdata, core_wbe,
    output core_wr_ack, core_read_valid, core_slv_error, core_rdata
  );
endinterface

// File: rtl/sha2_conduit_arbiter.sv
// rtl/sha2_conduit_arbiter.sv - round-robin sharing of one SHA2 core conduit; optional watchdog via SHA2_ARB_TIMEOUT_EN
module sha2_conduit_arbiter #(
  parameter int D_WIDTH        = 32,
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 pclk,
  input  logic                 preset,
  sha2_conduit_req_if.slave    req,
  sha2_conduit_core_if.master  core
);
  localparam int BW = D_WIDTH / 8;
  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sha2_conduit_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] slot_wr;
  logic [11:0]      slot_addr  [N_REQ];
  logic [D_WIDTH-1:0] slot_wdata [N_REQ];
  logic [BW-1:0]    slot_wbe   [N_REQ];
  logic [IW-1:0]    last;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    win;
  logic [IW-1:0]    cand;
  logic             win_vld;
  logic [N_REQ-1:0] grant;
  logic             any_cpl;

  assign any_cpl = core.core_slv_error | core.core_read_valid | core.core_wr_ack;

`ifdef SHA2_ARB_TIMEOUT_EN
  localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);
  // wd_cnt holds the number of cycles elapsed since the ISSUE cycle
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  assign wd_expired = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin pick: first pending requester after the last winner, with wrap-around
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (pend[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // One-hot grant, only meaningful on the IDLE cycle that launches an access
  always_comb begin
    grant = '0;
    if (state == S_IDLE && win_vld) grant[win] = 1'b1;
  end

  // Capture request pulses into slots; a new pulse in the grant cycle re-arms the slot
  always_ff @(posedge pclk) begin
    if (preset) begin
      pend        <= '0;
      slot_wr     <= '0;
      req.req_ovf <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        slot_wbe[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req.req_wr[i] || req.req_rd[i]) begin
          if (!pend[i] || grant[i]) begin
            pend[i]       <= 1'b1;
            slot_wr[i]    <= req.req_wr[i];
            slot_addr[i]  <= req.req_addr[i*12 +: 12];
            slot_wdata[i] <= req.req_wdata[i*D_WIDTH +: D_WIDTH];
            slot_wbe[i]   <= req.req_wbe[i*BW +: BW];
          end else begin
            req.req_ovf[i] <= 1'b1;
          end
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT -> DONE, all conduit outputs registered
  always_ff @(posedge pclk) begin
    if (preset) begin
      state              <= S_IDLE;
      last               <= IW'(N_REQ - 1);
      owner              <= '0;
      core.core_wr       <= 1'b0;
      core.core_rd       <= 1'b0;
      core.core_addr     <= '0;
      core.core_wdata    <= '0;
      core.core_wbe      <= '0;
      req.req_wr_ack     <= '0;
      req.req_read_valid <= '0;
      req.req_slv_error  <= '0;
      req.req_rdata      <= '0;
`ifdef SHA2_ARB_TIMEOUT_EN
      wd_cnt             <= '0;
`endif
    end else begin
      core.core_wr       <= 1'b0;
      core.core_rd       <= 1'b0;
      req.req_wr_ack     <= '0;
      req.req_read_valid <= '0;
      req.req_slv_error  <= '0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            core.core_wr    <= slot_wr[win];
            core.core_rd    <= ~slot_wr[win];
            core.core_addr  <= slot_addr[win];
            core.core_wdata <= slot_wdata[win];
            core.core_wbe   <= slot_wbe[win];
            owner           <= win;
            last            <= win;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (any_cpl) begin
            if (core.core_slv_error) begin
              req.req_slv_error[owner] <= 1'b1;
            end else if (core.core_read_valid) begin
              req.req_read_valid[owner] <= 1'b1;
              req.req_rdata[int'(owner)*D_WIDTH +: D_WIDTH] <= core.core_rdata;
            end else begin
              req.req_wr_ack[owner] <= 1'b1;
            end
            state <= S_DONE;
          end else if (state == S_ISSUE) begin
            state <= S_WAIT;
`ifdef SHA2_ARB_TIMEOUT_EN
          end else if (wd_expired) begin
            req.req_slv_error[owner] <= 1'b1;
            state <= S_DONE;
`endif
          end
`ifdef SHA2_ARB_TIMEOUT_EN
          if (state == S_ISSUE) wd_cnt <= WD_W'(1);
          else                  wd_cnt <= wd_cnt + WD_W'(1);
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha2_conduit_arbiter.sv
// tb/tb_sha2_conduit_arbiter.sv - self-checking bench for sha2_conduit_arbiter
module tb_sha2_conduit_arbiter;
  localparam int D_WIDTH = 32;
  localparam int N_REQ   = 2;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  int   cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  sha2_conduit_req_if  #(.D_WIDTH(D_WIDTH), .N_REQ(N_REQ)) rif();
  sha2_conduit_core_if #(.D_WIDTH(D_WIDTH))                cif();

  sha2_conduit_arbiter #(.D_WIDTH(D_WIDTH), .N_REQ(N_REQ), .TIMEOUT_CYCLES(8)) dut (
    .pclk   (pclk),
    .preset (preset),
    .req    (rif),
    .core   (cif)
  );

  typedef struct {
    int          idx;
    int          kind;   // 0 wr_ack, 1 read_valid, 2 slv_error
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    int          idx;
    bit          wr;
    bit          rd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    int          cpl;    // 0 ack, 1 read_valid, 2 error, 3 error+read_valid
    int          d;      // cycles from strobe to completion
    logic [31:0] rdata;
  } vec_t;

  exp_t        sb[$];
  exp_t        mx;
  vec_t        vecs[7];
  logic [31:0] rdm[N_REQ];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [N_REQ-1:0] mon_oh;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit wr, input bit rd, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    rif.req_wr[i] = wr;
    rif.req_rd[i] = rd;
    rif.req_addr[i*12 +: 12] = a;
    rif.req_wdata[i*32 +: 32] = wd;
    rif.req_wbe[i*4 +: 4] = be;
  endtask

  task automatic clr_req();
    rif.req_wr = '0;
    rif.req_rd = '0;
  endtask

  task automatic wait_strobe(output bit found, output int s);
    found = 1'b0;
    s = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge pclk);
      if (cif.core_wr || cif.core_rd) begin
        found = 1'b1;
        s = cyc;
        break;
      end
    end
    if (!found) chk("strobe_timeout", 1, 0);
  endtask

  task automatic serve(input int idx, input bit is_wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int cpl, input int d, input logic [31:0] rd_data,
                       input int exp_s, output int s);
    bit found;
    int kind;
    wait_strobe(found, s);
    if (!found) return;
    chk("strobe_cycle", s, exp_s);
    chk("core_wr", cif.core_wr, is_wr);
    chk("core_rd", cif.core_rd, !is_wr);
    chk("core_addr", cif.core_addr, a);
    chk("core_wdata", cif.core_wdata, wd);
    chk("core_wbe", cif.core_wbe, be);
    repeat (d) @(negedge pclk);
    cif.core_wr_ack     = (cpl == 0);
    cif.core_read_valid = (cpl == 1 || cpl == 3);
    cif.core_slv_error  = (cpl >= 2);
    cif.core_rdata      = rd_data;
    kind = (cpl == 3) ? 2 : cpl;
    sb.push_back('{idx, kind, rd_data, s + d + 1});
    if (kind == 1) rdm[idx] = rd_data;
    @(negedge pclk);
    cif.core_wr_ack = 1'b0;
    cif.core_read_valid = 1'b0;
    cif.core_slv_error = 1'b0;
    cif.core_rdata = '0;
    for (int r = 0; r < N_REQ; r++) chk($sformatf("rdata_hold%0d", r), rif.req_rdata[r*32 +: 32], rdm[r]);
  endtask

  task automatic rr_pair(input int first, input logic [11:0] base);
    int c0;
    int s;
    int second;
    logic [11:0] pa[2];
    logic [31:0] pw[2];
    logic [3:0]  pb[2];
    second = 1 - first;
    pa[0] = base; pa[1] = base + 12'h4;
    pw[0] = 32'hA000_0000 | 32'(base); pw[1] = 32'hB000_0000 | 32'(base);
    pb[0] = 4'hF; pb[1] = 4'h3;
    @(posedge pclk); #1;
    set_req(0, 1, 0, pa[0], pw[0], pb[0]);
    set_req(1, 1, 0, pa[1], pw[1], pb[1]);
    c0 = cyc;
    @(posedge pclk); #1;
    clr_req();
    serve(first, 1, pa[first], pw[first], pb[first], 0, 2, 32'h0, c0 + 2, s);
    serve(second, 1, pa[second], pw[second], pb[second], 0, 2, 32'h0, s + 5, s);
  endtask

  // Response monitor: every requester pulse must match the head of the scoreboard
  always @(negedge pclk) begin
    if (|{rif.req_wr_ack, rif.req_read_valid, rif.req_slv_error}) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {rif.req_slv_error, rif.req_read_valid, rif.req_wr_ack}, 0);
      end else begin
        mx = sb.pop_front();
        mon_oh = '0;
        mon_oh[mx.idx] = 1'b1;
        chk("resp_cycle", cyc, mx.cyc);
        chk("resp_wr_ack", rif.req_wr_ack, (mx.kind == 0) ? mon_oh : '0);
        chk("resp_read_valid", rif.req_read_valid, (mx.kind == 1) ? mon_oh : '0);
        chk("resp_slv_error", rif.req_slv_error, (mx.kind == 2) ? mon_oh : '0);
        if (mx.kind == 1) chk("resp_rdata", rif.req_rdata[mx.idx*32 +: 32], mx.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    int  s;
    int  n_str;
    bit  found;

    vecs[0] = '{0, 1, 0, 12'h010, 32'hDEADBEEF, 4'hF, 0, 2, 32'h0};
    vecs[1] = '{1, 0, 1, 12'h020, 32'h0,        4'h0, 1, 1, 32'h12345678};
    vecs[2] = '{0, 0, 1, 12'h030, 32'h0,        4'h0, 1, 0, 32'hA5A50001};
    vecs[3] = '{0, 1, 0, 12'h044, 32'h0BADF00D, 4'h3, 2, 0, 32'h0};
    vecs[4] = '{0, 0, 1, 12'h050, 32'h0,        4'h0, 3, 1, 32'hFFFF0000};
    vecs[5] = '{1, 1, 1, 12'h06C, 32'h13572468, 4'hC, 0, 3, 32'h0};
    vecs[6] = '{1, 0, 1, 12'h7FC, 32'h0,        4'h0, 1, 0, 32'hCAFE0001};

    for (int r = 0; r < N_REQ; r++) rdm[r] = '0;
    rif.req_wr = '0; rif.req_rd = '0; rif.req_addr = '0; rif.req_wdata = '0; rif.req_wbe = '0;
    cif.core_wr_ack = 1'b0; cif.core_read_valid = 1'b0; cif.core_slv_error = 1'b0; cif.core_rdata = '0;

    preset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_core_wr", cif.core_wr, 0);
    chk("rst_core_rd", cif.core_rd, 0);
    chk("rst_core_addr", cif.core_addr, 0);
    chk("rst_core_wdata", cif.core_wdata, 0);
    chk("rst_core_wbe", cif.core_wbe, 0);
    chk("rst_wr_ack", rif.req_wr_ack, 0);
    chk("rst_read_valid", rif.req_read_valid, 0);
    chk("rst_slv_error", rif.req_slv_error, 0);
    chk("rst_rdata", rif.req_rdata, 0);
    chk("rst_ovf", rif.req_ovf, 0);
    @(posedge pclk); #1;
    preset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(posedge pclk); #1;
      set_req(vecs[i].idx, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wbe);
      c0 = cyc;
      @(posedge pclk); #1;
      clr_req();
      serve(vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wbe,
            vecs[i].cpl, vecs[i].d, vecs[i].rdata, c0 + 2, s);
    end

    rr_pair(0, 12'h300);
    @(posedge pclk); #1;
    set_req(0, 1, 0, 12'h308, 32'h0000_0308, 4'h1);
    c0 = cyc;
    @(posedge pclk); #1;
    clr_req();
    serve(0, 1, 12'h308, 32'h0000_0308, 4'h1, 0, 1, 32'h0, c0 + 2, s);
    rr_pair(1, 12'h310);

    @(posedge pclk); #1;
    set_req(1, 0, 1, 12'h100, 32'h0, 4'h0);
    c0 = cyc;
    @(posedge pclk); #1;
    clr_req();
    fork
      serve(1, 0, 12'h100, 32'h0, 4'h0, 1, 6, 32'h0F0F0F0F, c0 + 2, s);
      begin
        repeat (2) @(posedge pclk); #1;
        set_req(0, 1, 0, 12'h004, 32'h0000_0004, 4'h1);
        @(posedge pclk); #1;
        set_req(0, 1, 0, 12'h008, 32'h0000_0008, 4'h2);
        @(posedge pclk); #1;
        clr_req();
      end
    join
    serve(0, 1, 12'h004, 32'h0000_0004, 4'h1, 0, 1, 32'h0, c0 + 11, s);
    chk("ovf_after_dup", rif.req_ovf, 2'b01);
    n_str = 0;
    repeat (8) begin
      @(negedge pclk);
      if (cif.core_wr || cif.core_rd) n_str++;
    end
    chk("dup_dropped", n_str, 0);

    @(posedge pclk); #1;
    set_req(1, 1, 0, 12'h200, 32'h0000_0200, 4'hF);
    c0 = cyc;
    @(posedge pclk); #1;
    set_req(1, 1, 0, 12'h204, 32'h0000_0204, 4'hE);
    @(posedge pclk); #1;
    clr_req();
    serve(1, 1, 12'h200, 32'h0000_0200, 4'hF, 0, 1, 32'h0, c0 + 2, s);
    serve(1, 1, 12'h204, 32'h0000_0204, 4'hE, 0, 1, 32'h0, s + 4, s);
    chk("ovf_set_beats_clear", rif.req_ovf, 2'b01);

`ifdef SHA2_ARB_TIMEOUT_EN
    @(posedge pclk); #1;
    set_req(0, 1, 0, 12'h0F0, 32'h0000_00F0, 4'hF);
    @(posedge pclk); #1;
    clr_req();
    wait_strobe(found, s);
    sb.push_back('{0, 2, 32'h0, s + 8});
    repeat (10) @(negedge pclk);
`endif

    @(posedge pclk); #1;
    set_req(0, 1, 0, 12'h3F0, 32'h0000_03F0, 4'hF);
    c0 = cyc;
    @(posedge pclk); #1;
    clr_req();
    wait_strobe(found, s);
    chk("abort_strobe_cycle", s, c0 + 2);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    chk("abort_core_wr", cif.core_wr, 0);
    chk("abort_core_addr", cif.core_addr, 0);
    chk("abort_core_wdata", cif.core_wdata, 0);
    chk("abort_resp", {rif.req_slv_error, rif.req_read_valid, rif.req_wr_ack}, 0);
    chk("abort_rdata", rif.req_rdata, 0);
    chk("abort_ovf", rif.req_ovf, 0);
    preset = 1'b0;
    for (int r = 0; r < N_REQ; r++) rdm[r] = '0;
    @(negedge pclk);
    cif.core_wr_ack = 1'b1;
    @(negedge pclk);
    cif.core_wr_ack = 1'b0;
    repeat (3) @(negedge pclk);

    rr_pair(0, 12'h3A0);

    for (int t = 0; t < 10; t++) begin
      if (sb.size() == 0) break;
      @(negedge pclk);
    end
    chk("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
